// File: rtl/dm_abs_cmd_ctrl.sv
// dm_abs_cmd_ctrl: Debug Module abstract-command sequencer for Access Register commands.
//   sys_clk, sys_rstn            : clock, asynchronous active-low reset
//   command, cmd_update, data0   : command word, write strobe and data0 from the DM register file
//   cmd_finished, cmd_read_data  : one-cycle completion pulse and read result back to the register file
//   hart_halted                  : hart is in debug mode
//   cmderr_clr, cmderr, busy     : abstractcs.cmderr write-1-to-clear mask, cmderr and busy
//   dbg_reg_*                    : core debug register port (req/wr/is_gpr/addr/wdata out, ack/err/rdata in)
module dm_abs_cmd_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rstn,
    input  logic [DATA_WIDTH-1:0] command,
    input  logic                  cmd_update,
    input  logic [DATA_WIDTH-1:0] data0,
    output logic                  cmd_finished,
    output logic [DATA_WIDTH-1:0] cmd_read_data,
    input  logic                  hart_halted,
    input  logic [2:0]            cmderr_clr,
    output logic [2:0]            cmderr,
    output logic                  busy,
    output logic                  dbg_reg_req,
    output logic                  dbg_reg_wr,
    output logic                  dbg_reg_is_gpr,
    output logic [11:0]           dbg_reg_addr,
    output logic [DATA_WIDTH-1:0] dbg_reg_wdata,
    input  logic                  dbg_reg_ack,
    input  logic                  dbg_reg_err,
    input  logic [DATA_WIDTH-1:0] dbg_reg_rdata
);
    typedef enum logic [1:0] {IDLE, DECODE, ACCESS, DONE} state_t;

    state_t                state;
    logic [7:0]            cmdtype_q;
    logic [2:0]            aarsize_q;
    logic                  postexec_q;
    logic                  transfer_q;
    logic                  write_q;
    logic [15:0]           regno_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [CNT_W-1:0]      cnt;
    logic                  dec_bad;
    logic                  is_gpr;
    logic                  reg_ok;
    logic                  go_access;
    logic                  timeout;
    logic [2:0]            err_code;
    logic [2:0]            cmderr_d;

    always_comb begin
        dec_bad   = (cmdtype_q != 8'd0) || (aarsize_q != 3'd2) || postexec_q;
        is_gpr    = regno_q[15:5] == 11'h080;
        reg_ok    = (regno_q[15:12] == 4'h0) || is_gpr;
        go_access = (cmderr == 3'd0) && !dec_bad && transfer_q && reg_ok && hart_halted;
        timeout   = cnt == CNT_W'(TIMEOUT_CYCLES - 1);
        // Decode/access errors take precedence over the busy-write error raised in the same cycle
        err_code  = (state == DECODE && cmderr == 3'd0 && dec_bad)                               ? 3'd2 :
                    (state == DECODE && cmderr == 3'd0 && transfer_q && !reg_ok)                 ? 3'd2 :
                    (state == DECODE && cmderr == 3'd0 && transfer_q && !hart_halted)            ? 3'd4 :
                    (state == ACCESS && dbg_reg_ack && dbg_reg_err)                              ? 3'd3 :
                    (state == ACCESS && !dbg_reg_ack && timeout)                                 ? 3'd3 :
                    (state != IDLE && cmd_update)                                                ? 3'd1 : 3'd0;
        // A new error beats a simultaneous clear but never replaces an existing code
        cmderr_d  = (err_code != 3'd0) ? ((cmderr == 3'd0) ? err_code : cmderr) : (cmderr & ~cmderr_clr);
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state          <= IDLE;
            cmdtype_q      <= '0;
            aarsize_q      <= '0;
            postexec_q     <= 1'b0;
            transfer_q     <= 1'b0;
            write_q        <= 1'b0;
            regno_q        <= '0;
            data_q         <= '0;
            cnt            <= '0;
            cmderr         <= '0;
            busy           <= 1'b0;
            cmd_finished   <= 1'b0;
            cmd_read_data  <= '0;
            dbg_reg_req    <= 1'b0;
            dbg_reg_wr     <= 1'b0;
            dbg_reg_is_gpr <= 1'b0;
            dbg_reg_addr   <= '0;
            dbg_reg_wdata  <= '0;
        end else begin
            cmderr        <= cmderr_d;
            cmd_finished  <= 1'b0;
            cmd_read_data <= '0;
            case (state)
                IDLE: if (cmd_update) begin
                    cmdtype_q  <= command[31:24];
                    aarsize_q  <= command[22:20];
                    postexec_q <= command[18];
                    transfer_q <= command[17];
                    write_q    <= command[16];
                    regno_q    <= command[15:0];
                    data_q     <= data0;
                    busy       <= 1'b1;
                    state      <= DECODE;
                end
                DECODE: if (go_access) begin
                    dbg_reg_req    <= 1'b1;
                    dbg_reg_wr     <= write_q;
                    dbg_reg_is_gpr <= is_gpr;
                    dbg_reg_addr   <= is_gpr ? {7'd0, regno_q[4:0]} : regno_q[11:0];
                    dbg_reg_wdata  <= data_q;
                    cnt            <= '0;
                    state          <= ACCESS;
                end else begin
                    cmd_finished <= 1'b1;
                    state        <= DONE;
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (dbg_reg_ack || timeout) begin
                        dbg_reg_req    <= 1'b0;
                        dbg_reg_wr     <= 1'b0;
                        dbg_reg_is_gpr <= 1'b0;
                        dbg_reg_addr   <= '0;
                        dbg_reg_wdata  <= '0;
                        cmd_finished   <= 1'b1;
                        cmd_read_data  <= (dbg_reg_ack && !dbg_reg_err && !dbg_reg_wr) ? dbg_reg_rdata : '0;
                        state          <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dm_abs_cmd_ctrl.sv
// tb_dm_abs_cmd_ctrl: scoreboard bench for dm_abs_cmd_ctrl with a simple core register port model.
module tb_dm_abs_cmd_ctrl;
    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic [31:0] command = '0;
    logic        cmd_update = 1'b0;
    logic [31:0] data0 = '0;
    logic        cmd_finished;
    logic [31:0] cmd_read_data;
    logic        hart_halted = 1'b0;
    logic [2:0]  cmderr_clr = '0;
    logic [2:0]  cmderr;
    logic        busy;
    logic        dbg_reg_req;
    logic        dbg_reg_wr;
    logic        dbg_reg_is_gpr;
    logic [11:0] dbg_reg_addr;
    logic [31:0] dbg_reg_wdata;
    logic        dbg_reg_ack = 1'b0;
    logic        dbg_reg_err = 1'b0;
    logic [31:0] dbg_reg_rdata = '0;

    dm_abs_cmd_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .CNT_W(8)) dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn), .command(command), .cmd_update(cmd_update),
        .data0(data0), .cmd_finished(cmd_finished), .cmd_read_data(cmd_read_data),
        .hart_halted(hart_halted), .cmderr_clr(cmderr_clr), .cmderr(cmderr), .busy(busy),
        .dbg_reg_req(dbg_reg_req), .dbg_reg_wr(dbg_reg_wr), .dbg_reg_is_gpr(dbg_reg_is_gpr),
        .dbg_reg_addr(dbg_reg_addr), .dbg_reg_wdata(dbg_reg_wdata), .dbg_reg_ack(dbg_reg_ack),
        .dbg_reg_err(dbg_reg_err), .dbg_reg_rdata(dbg_reg_rdata)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] rdata;
        logic [2:0]  err;
        int          cyc;
        int          req_n;
        logic        wr;
        logic        gpr;
        logic [11:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        q[$];
    int          passed = 0;
    int          total = 0;
    int          cyc = 0;
    int          nfin = 0;
    int          ack_delay = 0;
    logic        core_err = 1'b0;
    logic [31:0] core_rdata = '0;
    int          req_n = 0;
    logic        cap_wr, cap_gpr;
    logic [11:0] cap_addr;
    logic [31:0] cap_wdata;

    always @(posedge sys_clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Core register port model plus scoreboard monitor
    always @(negedge sys_clk) begin
        if (!sys_rstn) begin
            dbg_reg_ack = 1'b0;
            req_n = 0;
        end else begin
            if (dbg_reg_req) begin
                req_n++;
                if (req_n == 1) begin
                    cap_wr = dbg_reg_wr;
                    cap_gpr = dbg_reg_is_gpr;
                    cap_addr = dbg_reg_addr;
                    cap_wdata = dbg_reg_wdata;
                end
                dbg_reg_ack = (ack_delay != 0) && (req_n == ack_delay);
                dbg_reg_err = core_err;
                dbg_reg_rdata = core_rdata;
            end else dbg_reg_ack = 1'b0;
            if (cmd_finished) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_finished: got cmd_finished=1 expected no pending command (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("finish_cycle", cyc, e.cyc);
                    check("read_data", cmd_read_data, e.rdata);
                    check("cmderr_at_finish", {29'd0, cmderr}, {29'd0, e.err});
                    check("req_cycles", req_n, e.req_n);
                    if (e.req_n > 0) begin
                        check("req_wr", {31'd0, cap_wr}, {31'd0, e.wr});
                        check("req_is_gpr", {31'd0, cap_gpr}, {31'd0, e.gpr});
                        check("req_addr", {20'd0, cap_addr}, {20'd0, e.addr});
                        check("req_wdata", cap_wdata, e.wdata);
                    end
                end
                nfin++;
                req_n = 0;
            end
        end
    end

    task automatic issue(input logic [31:0] cmd, input logic [31:0] d0, input int lat, input logic [31:0] rd,
                         input logic [2:0] err, input int rn, input logic wr, input logic gpr,
                         input logic [11:0] addr);
        exp_t e;
        @(posedge sys_clk); #1;
        command = cmd;
        data0 = d0;
        cmd_update = 1'b1;
        e.rdata = rd; e.err = err; e.cyc = cyc + lat; e.req_n = rn;
        e.wr = wr; e.gpr = gpr; e.addr = addr; e.wdata = d0;
        q.push_back(e);
        @(posedge sys_clk); #1;
        cmd_update = 1'b0;
    endtask

    task automatic wait_fin();
        int n0 = nfin;
        int k = 0;
        while (nfin == n0 && k < 60) begin
            @(negedge sys_clk);
            #1;
            k++;
        end
        if (nfin == n0) begin
            total++;
            $display("FAIL finish_timeout: got no cmd_finished expected one within 60 cycles");
        end
    endtask

    task automatic clear_err();
        @(posedge sys_clk); #1;
        cmderr_clr = 3'b111;
        @(posedge sys_clk); #1;
        cmderr_clr = 3'b000;
        check("cmderr_cleared", {29'd0, cmderr}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge sys_clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_cmderr", {29'd0, cmderr}, 32'd0);
        check("reset_req", {31'd0, dbg_reg_req}, 32'd0);
        sys_rstn = 1'b1;
        hart_halted = 1'b1;

        // Read x5, ack after 4 request cycles
        ack_delay = 4; core_rdata = 32'hDEADBEEF;
        issue(32'h0022_1005, 32'h0, 6, 32'hDEADBEEF, 3'd0, 4, 1'b0, 1'b1, 12'h005);
        wait_fin();
        @(posedge sys_clk); #1;
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("rdata_after_done", cmd_read_data, 32'd0);

        // Write mepc, same-cycle ack; read data must stay zero for a write
        ack_delay = 1;
        issue(32'h0023_0341, 32'h1234_5678, 3, 32'h0, 3'd0, 1, 1'b1, 1'b0, 12'h341);
        wait_fin();

        // Not halted -> cmderr 4; then a valid command is suppressed by the sticky error
        hart_halted = 1'b0;
        issue(32'h0022_1001, 32'h0, 2, 32'h0, 3'd4, 0, 1'b0, 1'b0, 12'h0);
        wait_fin();
        hart_halted = 1'b1;
        issue(32'h0022_1001, 32'h0, 2, 32'h0, 3'd4, 0, 1'b0, 1'b0, 12'h0);
        wait_fin();
        clear_err();

        // Decode errors: aarsize=3, postexec=1, regno just past the GPR window
        issue(32'h0032_1001, 32'h0, 2, 32'h0, 3'd2, 0, 1'b0, 1'b0, 12'h0);
        wait_fin(); clear_err();
        issue(32'h0026_1001, 32'h0, 2, 32'h0, 3'd2, 0, 1'b0, 1'b0, 12'h0);
        wait_fin(); clear_err();
        issue(32'h0022_1020, 32'h0, 2, 32'h0, 3'd2, 0, 1'b0, 1'b0, 12'h0);
        wait_fin(); clear_err();

        // transfer=0: completes without access or error
        issue(32'h0020_1005, 32'h0, 2, 32'h0, 3'd0, 0, 1'b0, 1'b0, 12'h0);
        wait_fin();

        // Range edges: last CSR and last GPR
        ack_delay = 2; core_rdata = 32'hA5A5_0FFF;
        issue(32'h0022_0FFF, 32'h0, 4, 32'hA5A5_0FFF, 3'd0, 2, 1'b0, 1'b0, 12'hFFF);
        wait_fin();
        core_rdata = 32'h0000_101F;
        issue(32'h0022_101F, 32'h0, 4, 32'h0000_101F, 3'd0, 2, 1'b0, 1'b1, 12'h01F);
        wait_fin();

        // Timeout: no ack for 8 cycles
        ack_delay = 0;
        issue(32'h0022_1002, 32'h0, 10, 32'h0, 3'd3, 8, 1'b0, 1'b1, 12'h002);
        wait_fin(); clear_err();

        // Faulted access
        ack_delay = 1; core_err = 1'b1; core_rdata = 32'hFFFF_FFFF;
        issue(32'h0022_1004, 32'h0, 3, 32'h0, 3'd3, 1, 1'b0, 1'b1, 12'h004);
        wait_fin(); clear_err();
        core_err = 1'b0;

        // cmd_update while busy -> cmderr 1, only one finish
        ack_delay = 5; core_rdata = 32'h1122_3344;
        issue(32'h0022_1003, 32'h0, 7, 32'h1122_3344, 3'd1, 5, 1'b0, 1'b1, 12'h003);
        @(posedge sys_clk); #1;
        command = 32'h0022_1009; cmd_update = 1'b1;
        @(posedge sys_clk); #1;
        cmd_update = 1'b0;
        check("busy_write_cmderr", {29'd0, cmderr}, 32'd1);
        wait_fin();
        repeat (4) @(posedge sys_clk);
        clear_err();

        // Reset in the middle of an access
        ack_delay = 0;
        @(posedge sys_clk); #1;
        command = 32'h0022_1007; cmd_update = 1'b1;
        @(posedge sys_clk); #1;
        cmd_update = 1'b0;
        @(posedge sys_clk); #1;
        check("access_req_high", {31'd0, dbg_reg_req}, 32'd1);
        cmd_update = 1'b1;
        @(posedge sys_clk); #1;
        cmd_update = 1'b0;
        check("pre_reset_cmderr", {29'd0, cmderr}, 32'd1);
        sys_rstn = 1'b0;
        #1;
        check("rst_req", {31'd0, dbg_reg_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmderr", {29'd0, cmderr}, 32'd0);
        repeat (2) @(posedge sys_clk);
        #1 sys_rstn = 1'b1;
        repeat (12) @(posedge sys_clk);
        #1;
        check("queue_drained", q.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dm_abs_cmd_ctrl.md
Name: dm_abs_cmd_ctrl

Overview:
Abstract-command sequencer for the Debug Module. It consumes the command word and cmd_update strobe from the DM register file, then decodes Access Register commands (RISC-V Debug 0.13, cmdtype 0). It runs one GPR/CSR read or write on the core debug register port and returns cmd_finished and cmd_read_data to the register file. It owns abstractcs.busy and abstractcs.cmderr.

Parameters:
DATA_WIDTH, 32, width of data0, command and core register data
TIMEOUT_CYCLES, 255, maximum cycles in ACCESS waiting for dbg_reg_ack
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
sys_clk  in  1  clock
sys_rstn  in  1  reset; asynchronous, active-low
command  in  DATA_WIDTH  abstract command register value
cmd_update  in  1  one-cycle pulse: command was written
data0  in  DATA_WIDTH  data0 register value (write source)
cmd_finished  out  1  one-cycle pulse: the accepted command has completed
cmd_read_data  out  DATA_WIDTH  read result; nonzero only during cmd_finished
hart_halted  in  1  hart is in debug mode
cmderr_clr  in  3  write-1-to-clear mask for cmderr (abstractcs write)
cmderr  out  3  abstractcs.cmderr
busy  out  1  abstractcs.busy
dbg_reg_req  out  1  core register access request
dbg_reg_wr  out  1  1 = write, 0 = read
dbg_reg_is_gpr  out  1  1 = GPR, 0 = CSR
dbg_reg_addr  out  12  GPR index [4:0] or CSR address
dbg_reg_wdata  out  DATA_WIDTH  write data
dbg_reg_ack  in  1  access complete
dbg_reg_err  in  1  access faulted; valid with ack
dbg_reg_rdata  in  DATA_WIDTH  read data; valid with ack

Behaviour:
- Reset: state IDLE. All outputs 0: cmderr=0, busy=0, dbg_reg_* =0, timeout counter 0.
- Decode fields: cmdtype=[31:24], aarsize=[22:20], postexec=[18], transfer=[17], write=[16], regno=[15:0].
- FSM states: IDLE, DECODE, ACCESS, DONE. busy=1 in every state except IDLE.
- IDLE: when cmd_update=1, latch command and data0, then go to DECODE.
- DECODE (single cycle), checks in priority order:
  1. cmderr!=0: no action, go to DONE.
  2. cmdtype!=0, or aarsize!=2, or postexec=1: cmderr=2, go to DONE.
  3. transfer=0: go to DONE.
  4. regno outside 0x0000-0x0FFF (CSR) and outside 0x1000-0x101F (GPR): cmderr=2, go to DONE.
  5. hart_halted=0: cmderr=4, go to DONE.
  6. Otherwise: go to ACCESS.
- ACCESS:
  - dbg_reg_req=1 with wr, is_gpr, addr and wdata held stable; timeout counter increments each cycle.
  - On dbg_reg_ack=1 (same-cycle ack allowed): drop req next cycle, go to DONE.
    - dbg_reg_err=1: cmderr=3.
    - Else, on a read: capture dbg_reg_rdata.
  - When the counter reaches TIMEOUT_CYCLES with no ack: cmderr=3, go to DONE.
  - hart_halted falling during ACCESS is ignored.
- DONE: cmd_finished=1 for exactly one cycle. cmd_read_data = captured value for a successful read, otherwise 0. Next state IDLE.
- Latency, with cmd_update in cycle 0:
  - non-access command: cmd_finished in cycle 2.
  - access acked in its first cycle: cmd_finished in cycle 3.
- Every cmd_update accepted in IDLE produces exactly one cmd_finished.
- cmd_update while busy: cmderr=1 if cmderr was 0. Command not latched, no extra cmd_finished.
- cmderr:
  - Bits clear where cmderr_clr=1.
  - A set in the same cycle overrides the clear.
  - A nonzero value is never overwritten by another error code.
- Reset mid-access: FSM returns to IDLE immediately and req drops. No cmd_finished is produced.

Test Plan:
- Halted; command=0x0022_1005 (read x5); core acks after 4 cycles with rdata 0xDEADBEEF -> req high 4 cycles, addr=5, is_gpr=1, wr=0. cmd_finished pulses once with cmd_read_data=0xDEADBEEF; busy low next cycle; cmderr=0.
- Halted; data0=0x1234_5678, command=0x0023_0341 (write mepc) -> req with wr=1, is_gpr=0, addr=0x341, wdata=0x12345678. On ack: cmd_finished=1, cmd_read_data=0.
- Not halted; command=0x0022_1001 -> no req; cmderr=4; cmd_finished in cycle 2. Then a valid command: no access (cmderr stays 4), finished in cycle 2. cmderr_clr=0b111 -> cmderr=0.
- aarsize=3 (0x0032_1001) -> cmderr=2. postexec=1 -> cmderr=2. regno=0x1020 -> cmderr=2. None of these issues a req.
- Core never acks, TIMEOUT_CYCLES=8 -> req high exactly 8 cycles; cmderr=3; single cmd_finished.
- Second cmd_update during ACCESS -> cmderr=1; one cmd_finished only. Assert sys_rstn low mid-ACCESS -> req=0, busy=0, cmderr=0 immediately.
